// File: rtl/traffic_conflict_monitor.sv
// -----------------------------------------------------------------------------
// traffic_conflict_monitor
//
// Independent safety monitor for the traffic controller's lamp interface.
// Every clock it samples the four approach lamp triplets and the four walk
// signals. It checks them against the intersection safety rules and latches a
// fault with a cause code. The latched fault drives the all-red override.
//
// Ports
//   clk                   system clock, lamps sampled on every rising edge
//   reset                 synchronous active-high reset
//   sN_r/sN_g/sN_y        lamp drives for approach N (1..4)
//   P1..P4                walk signals (only P3/P4 can conflict with traffic)
//   clear_fault           single-cycle request to leave the fault state
//   fault, force_red      latched fault / all-red override (identical)
//   fault_code            0 none, 1 illegal lamp, 2 group conflict,
//                         3 walk conflict, 4 short yellow
//   armed                 high while actively monitoring (MONITOR/PENDING)
//   fault_cnt             saturating count of fault entries since reset
// -----------------------------------------------------------------------------
module traffic_conflict_monitor #(
    parameter int PERSIST = 2,
    parameter int MIN_YEL = 134217728,
    parameter int YCNT_W  = 28
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s1_r,
    input  logic       s1_g,
    input  logic       s1_y,
    input  logic       s2_r,
    input  logic       s2_g,
    input  logic       s2_y,
    input  logic       s3_r,
    input  logic       s3_g,
    input  logic       s3_y,
    input  logic       s4_r,
    input  logic       s4_g,
    input  logic       s4_y,
    input  logic       P1,
    input  logic       P2,
    input  logic       P3,
    input  logic       P4,
    input  logic       clear_fault,
    output logic       fault,
    output logic       force_red,
    output logic [2:0] fault_code,
    output logic       armed,
    output logic [7:0] fault_cnt
);

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_MONITOR = 2'd1,
        ST_PENDING = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    localparam logic [YCNT_W-1:0] MIN_YEL_C = YCNT_W'(MIN_YEL);
    localparam logic [YCNT_W-1:0] YCNT_ZERO = {YCNT_W{1'b0}};
    localparam logic [YCNT_W-1:0] YCNT_ONE  = {{(YCNT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]        PERSIST_C = 4'(PERSIST);

    localparam logic [2:0] CODE_NONE    = 3'd0;
    localparam logic [2:0] CODE_ILLEGAL = 3'd1;
    localparam logic [2:0] CODE_GROUP   = 3'd2;
    localparam logic [2:0] CODE_WALK    = 3'd3;
    localparam logic [2:0] CODE_SHORT_Y = 3'd4;

    // Lamps gathered into per-colour vectors, bit i = approach i+1.
    logic [3:0] lamp_r_s;
    logic [3:0] lamp_g_s;
    logic [3:0] lamp_y_s;
    logic [3:0] one_hot_s;
    logic [3:0] red_only_s;
    logic [3:0] go_s;
    logic [3:0] yel_short_s;
    logic       illegal_s;
    logic       group_s;
    logic       walk_s;
    logic       short_s;
    logic       static_s;
    logic       any_s;
    logic       all_red_s;
    logic [2:0] code_s;
    logic       unused_walk_s;

    logic [YCNT_W-1:0] ycnt_r [4];
    state_t            state_r;
    state_t            state_d;
    logic [3:0]        pcnt_r;
    logic [3:0]        pcnt_d;
    logic              fault_d;
    logic              armed_d;
    logic [2:0]        code_d;
    logic [7:0]        cnt_d;

    assign lamp_r_s = {s4_r, s3_r, s2_r, s1_r};
    assign lamp_g_s = {s4_g, s3_g, s2_g, s1_g};
    assign lamp_y_s = {s4_y, s3_y, s2_y, s1_y};

    // P1/P2 cross group A only, which never conflicts with its own walk.
    assign unused_walk_s = P1 | P2;

    assign one_hot_s  = (lamp_r_s & ~lamp_g_s & ~lamp_y_s) |
                        (~lamp_r_s & lamp_g_s & ~lamp_y_s) |
                        (~lamp_r_s & ~lamp_g_s & lamp_y_s);
    assign red_only_s = lamp_r_s & ~lamp_g_s & ~lamp_y_s;
    assign go_s       = lamp_g_s | lamp_y_s;

    assign illegal_s = |(~one_hot_s);
    assign group_s   = (go_s[0] | go_s[1]) & (go_s[2] | go_s[3]);
    assign walk_s    = (P3 | P4) & (go_s[2] | go_s[3]);
    assign all_red_s = &red_only_s;

    // A non-zero yellow counter means the yellow was lit last cycle; a red-only
    // approach with a counter still below the minimum ended its yellow early.
    always_comb begin
        yel_short_s = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            yel_short_s[i] = red_only_s[i] && (ycnt_r[i] != YCNT_ZERO) &&
                             (ycnt_r[i] < MIN_YEL_C);
        end
    end

    assign short_s  = |yel_short_s;
    assign static_s = illegal_s | group_s | walk_s;
    assign any_s    = static_s | short_s;

    // Cause code with fixed priority group > walk > illegal > short yellow.
    always_comb begin
        if (group_s) begin
            code_s = CODE_GROUP;
        end else if (walk_s) begin
            code_s = CODE_WALK;
        end else if (illegal_s) begin
            code_s = CODE_ILLEGAL;
        end else if (short_s) begin
            code_s = CODE_SHORT_Y;
        end else begin
            code_s = CODE_NONE;
        end
    end

    // Per-approach yellow duration counters, running in every state.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (reset) begin
                ycnt_r[i] <= YCNT_ZERO;
            end else if (lamp_y_s[i]) begin
                if (ycnt_r[i] < MIN_YEL_C) begin
                    ycnt_r[i] <= ycnt_r[i] + YCNT_ONE;
                end else begin
                    ycnt_r[i] <= ycnt_r[i];
                end
            end else begin
                ycnt_r[i] <= YCNT_ZERO;
            end
        end
    end

    // State and persist counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_STARTUP;
            pcnt_r  <= 4'd0;
        end else begin
            state_r <= state_d;
            pcnt_r  <= pcnt_d;
        end
    end

    // Next-state logic; a changing violation kind keeps counting in PENDING.
    always_comb begin
        state_d = state_r;
        pcnt_d  = pcnt_r;
        case (state_r)
            ST_STARTUP: begin
                pcnt_d = 4'd0;
                if (all_red_s) begin
                    state_d = ST_MONITOR;
                end else begin
                    state_d = ST_STARTUP;
                end
            end
            ST_MONITOR: begin
                if (short_s) begin
                    state_d = ST_FAULT;
                    pcnt_d  = 4'd0;
                end else if (static_s) begin
                    if (PERSIST_C <= 4'd1) begin
                        state_d = ST_FAULT;
                        pcnt_d  = 4'd0;
                    end else begin
                        state_d = ST_PENDING;
                        pcnt_d  = 4'd1;
                    end
                end else begin
                    state_d = ST_MONITOR;
                    pcnt_d  = 4'd0;
                end
            end
            ST_PENDING: begin
                if (!any_s) begin
                    state_d = ST_MONITOR;
                    pcnt_d  = 4'd0;
                end else if (short_s) begin
                    state_d = ST_FAULT;
                    pcnt_d  = 4'd0;
                end else if ((pcnt_r + 4'd1) >= PERSIST_C) begin
                    state_d = ST_FAULT;
                    pcnt_d  = 4'd0;
                end else begin
                    state_d = ST_PENDING;
                    pcnt_d  = pcnt_r + 4'd1;
                end
            end
            ST_FAULT: begin
                pcnt_d = 4'd0;
                if (clear_fault && !any_s) begin
                    state_d = ST_STARTUP;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                state_d = ST_STARTUP;
                pcnt_d  = 4'd0;
            end
        endcase
    end

    // Output decode from the next state so outputs update on the same edge.
    always_comb begin
        fault_d = (state_d == ST_FAULT);
        armed_d = (state_d == ST_MONITOR) || (state_d == ST_PENDING);
        if ((state_d == ST_FAULT) && (state_r != ST_FAULT)) begin
            code_d = code_s;
            if (fault_cnt != 8'hFF) begin
                cnt_d = fault_cnt + 8'd1;
            end else begin
                cnt_d = fault_cnt;
            end
        end else if (state_d == ST_FAULT) begin
            code_d = fault_code;
            cnt_d  = fault_cnt;
        end else begin
            code_d = CODE_NONE;
            cnt_d  = fault_cnt;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault      <= 1'b0;
            force_red  <= 1'b0;
            fault_code <= CODE_NONE;
            armed      <= 1'b0;
            fault_cnt  <= 8'd0;
        end else begin
            fault      <= fault_d;
            force_red  <= fault_d;
            fault_code <= code_d;
            armed      <= armed_d;
            fault_cnt  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// -----------------------------------------------------------------------------
// Testbench for traffic_conflict_monitor (PERSIST=2, MIN_YEL=4, YCNT_W=4).
// Directed scenarios plus a randomized run, each cycle compared against a
// behavioural model built from the safety rules.
// -----------------------------------------------------------------------------
module tb_traffic_conflict_monitor;

    localparam int PERSIST = 2;
    localparam int MIN_YEL = 4;
    localparam int YCNT_W  = 4;

    localparam logic [2:0] RD = 3'b100;   // {r,g,y}
    localparam logic [2:0] GR = 3'b010;
    localparam logic [2:0] YL = 3'b001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear_fault = 1'b0;
    logic [3:0] lr = 4'hF;
    logic [3:0] lg = 4'h0;
    logic [3:0] ly = 4'h0;
    logic [3:0] pw = 4'h0;
    logic       fault;
    logic       force_red;
    logic [2:0] fault_code;
    logic       armed;
    logic [7:0] fault_cnt;

    int errors = 0;
    int checks = 0;

    // behavioural model: mode 0 waiting for all-red, 1 watching, 2 faulted
    int m_mode = 0;
    int m_run  = 0;
    int m_code = 0;
    int m_cnt  = 0;
    int m_yl [4] = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    traffic_conflict_monitor #(
        .PERSIST(PERSIST), .MIN_YEL(MIN_YEL), .YCNT_W(YCNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .s1_r(lr[0]), .s1_g(lg[0]), .s1_y(ly[0]),
        .s2_r(lr[1]), .s2_g(lg[1]), .s2_y(ly[1]),
        .s3_r(lr[2]), .s3_g(lg[2]), .s3_y(ly[2]),
        .s4_r(lr[3]), .s4_g(lg[3]), .s4_y(ly[3]),
        .P1(pw[0]), .P2(pw[1]), .P3(pw[2]), .P4(pw[3]),
        .clear_fault(clear_fault),
        .fault(fault), .force_red(force_red), .fault_code(fault_code),
        .armed(armed), .fault_cnt(fault_cnt)
    );

    task automatic lamps(input logic [2:0] a1, input logic [2:0] a2,
                         input logic [2:0] a3, input logic [2:0] a4);
        {lr[0], lg[0], ly[0]} = a1;
        {lr[1], lg[1], ly[1]} = a2;
        {lr[2], lg[2], ly[2]} = a3;
        {lr[3], lg[3], ly[3]} = a4;
    endtask

    // One clock of the safety rules, applied to the inputs seen at this edge.
    task automatic model_step();
        int  nlit;
        bit  goa, gob, ill, shrt, allred, enter;
        int  code;
        if (reset) begin
            m_mode = 0; m_run = 0; m_code = 0; m_cnt = 0;
            for (int i = 0; i < 4; i++) m_yl[i] = 0;
            return;
        end
        goa = (lg[0] || ly[0] || lg[1] || ly[1]);
        gob = (lg[2] || ly[2] || lg[3] || ly[3]);
        ill = 0; shrt = 0; allred = 1; enter = 0;
        for (int i = 0; i < 4; i++) begin
            nlit = int'(lr[i]) + int'(lg[i]) + int'(ly[i]);
            if (nlit != 1) ill = 1;
            if (lr[i] && !lg[i] && !ly[i]) begin
                if (m_yl[i] > 0 && m_yl[i] < MIN_YEL) shrt = 1;
            end else begin
                allred = 0;
            end
        end
        if (goa && gob)                  code = 2;
        else if ((pw[2] || pw[3]) && gob) code = 3;
        else if (ill)                    code = 1;
        else if (shrt)                   code = 4;
        else                             code = 0;
        case (m_mode)
            0: if (allred) begin m_mode = 1; m_run = 0; end
            1: begin
                if (shrt) enter = 1;
                else if (code != 0) begin
                    m_run++;
                    if (m_run >= PERSIST) enter = 1;
                end else m_run = 0;
            end
            default: if (clear_fault && code == 0) begin m_mode = 0; m_code = 0; end
        endcase
        if (enter) begin
            m_mode = 2; m_run = 0; m_code = code;
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        end
        for (int i = 0; i < 4; i++)
            m_yl[i] = ly[i] ? ((m_yl[i] < MIN_YEL) ? m_yl[i] + 1 : MIN_YEL) : 0;
    endtask

    function automatic logic [13:0] obs_vec();
        return {fault, force_red, armed, fault_code, fault_cnt};
    endfunction

    function automatic logic [13:0] exp_vec();
        return {(m_mode == 2), (m_mode == 2), (m_mode == 1), 3'(m_code), 8'(m_cnt)};
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; clear_fault = 1'b0; pw = 4'h0;
        lamps(RD, RD, RD, RD);
        step(); step();
        checks++;
        if (obs_vec() !== 14'd0) begin
            errors++; $display("FAIL reset_values: actual=%h required=%h", obs_vec(), 14'd0);
        end
        reset = 1'b0;
    endtask

    task automatic test_arm();
        for (int i = 0; i < 7; i++) begin
            if (i == 0 || i == 6) lamps(RD, RD, RD, RD);
            else if (i == 1)      lamps(GR, GR, RD, RD);
            else                  lamps(YL, YL, RD, RD);
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL arm_seq[%0d]: actual=%h required=%h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if ({armed, fault, fault_cnt} !== {1'b1, 1'b0, 8'd0}) begin
            errors++; $display("FAIL arm_final: actual=%b/%b/%0d required=1/0/0", armed, fault, fault_cnt);
        end
    endtask

    task automatic test_group_conflict();
        lamps(GR, RD, GR, RD);
        step();
        lamps(RD, RD, RD, RD);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs_vec() !== exp_vec() || fault !== 1'b0) begin
                errors++; $display("FAIL group_short_pulse[%0d]: actual=%h required=%h", i, obs_vec(), exp_vec());
            end
        end
        lamps(GR, RD, GR, RD);
        step();
        checks++;
        if (fault !== 1'b0 || armed !== 1'b1) begin
            errors++; $display("FAIL group_first_edge: actual fault=%b armed=%b required 0/1", fault, armed);
        end
        step();
        checks++;
        if ({fault, force_red, fault_code, fault_cnt} !== {1'b1, 1'b1, 3'd2, 8'd1}) begin
            errors++; $display("FAIL group_fault: actual=%b/%b/%0d/%0d required=1/1/2/1",
                               fault, force_red, fault_code, fault_cnt);
        end
        lamps(RD, RD, RD, RD);
        clear_fault = 1'b1;
        step();
        clear_fault = 1'b0;
        step();
        checks++;
        if (obs_vec() !== exp_vec() || armed !== 1'b1) begin
            errors++; $display("FAIL group_rearm: actual=%h required=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_short_yellow();
        for (int len = 3; len <= 4; len++) begin
            lamps(RD, YL, RD, RD);
            for (int i = 0; i < len; i++) step();
            lamps(RD, RD, RD, RD);
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL yellow_len%0d_model: actual=%h required=%h", len, obs_vec(), exp_vec());
            end
            checks++;
            if (len == 3 && {fault, fault_code, fault_cnt} !== {1'b1, 3'd4, 8'd2}) begin
                errors++; $display("FAIL yellow_short: actual=%b/%0d/%0d required=1/4/2", fault, fault_code, fault_cnt);
            end else if (len == 4 && {fault, armed} !== 2'b01) begin
                errors++; $display("FAIL yellow_ok: actual fault=%b armed=%b required 0/1", fault, armed);
            end
            if (len == 3) begin
                clear_fault = 1'b1; step();
                clear_fault = 1'b0; step();
            end
        end
    endtask

    task automatic test_priority_clear();
        lamps(GR, RD, GR, RD); pw = 4'b0100;
        step(); step();
        checks++;
        if ({fault, fault_code, fault_cnt} !== {1'b1, 3'd2, 8'd3}) begin
            errors++; $display("FAIL prio_code: actual=%b/%0d/%0d required=1/2/3", fault, fault_code, fault_cnt);
        end
        clear_fault = 1'b1; step(); clear_fault = 1'b0;
        checks++;
        if (obs_vec() !== exp_vec() || fault !== 1'b1) begin
            errors++; $display("FAIL clear_blocked: actual=%h required=%h", obs_vec(), exp_vec());
        end
        lamps(RD, RD, RD, RD); pw = 4'h0;
        step();
        clear_fault = 1'b1; step(); clear_fault = 1'b0;
        checks++;
        if ({fault, force_red, armed, fault_code} !== {1'b0, 1'b0, 1'b0, 3'd0}) begin
            errors++; $display("FAIL clear_ok: actual=%b/%b/%b/%0d required=0/0/0/0", fault, force_red, armed, fault_code);
        end
        step();
        checks++;
        if (obs_vec() !== exp_vec() || armed !== 1'b1) begin
            errors++; $display("FAIL rearm_after_clear: actual=%h required=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_startup_ignore();
        reset = 1'b1; step(); reset = 1'b0;
        lamps(RD, RD, RD, 3'b110);
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({fault, armed} !== 2'b00 || obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL startup_ignore[%0d]: actual=%h required=%h", i, obs_vec(), exp_vec());
            end
        end
        lamps(RD, RD, RD, RD);
        step();
        checks++;
        if (armed !== 1'b1) begin
            errors++; $display("FAIL startup_arm: actual armed=%b required 1", armed);
        end
    endtask

    task automatic test_reset_in_fault();
        lamps(GR, RD, GR, RD);
        step(); step();
        checks++;
        if (fault !== 1'b1) begin
            errors++; $display("FAIL rst_fault_entry: actual fault=%b required 1", fault);
        end
        reset = 1'b1; clear_fault = 1'b1;
        step();
        reset = 1'b0; clear_fault = 1'b0;
        checks++;
        if (obs_vec() !== 14'd0) begin
            errors++; $display("FAIL reset_in_fault: actual=%h required=%h", obs_vec(), 14'd0);
        end
        lamps(RD, RD, RD, RD);
        step();
    endtask

    task automatic test_random();
        int sel;
        int ap;
        logic [2:0] pick;
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            clear_fault = ($urandom_range(0, 7) == 0);
            pw = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            sel = $urandom_range(0, 99);
            ap  = $urandom_range(0, 3);
            if (sel < 60) begin
                // keep lamps
            end else if (sel < 85) begin
                case ($urandom_range(0, 2))
                    0:       pick = RD;
                    1:       pick = GR;
                    default: pick = YL;
                endcase
                {lr[ap], lg[ap], ly[ap]} = pick;
            end else if (sel < 95) begin
                lamps(RD, RD, RD, RD);
            end else begin
                {lr[ap], lg[ap], ly[ap]} = 3'($urandom_range(0, 7));
            end
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL random[%0d]: actual=%h required=%h", n, obs_vec(), exp_vec());
            end
        end
        reset = 1'b0; clear_fault = 1'b0;
    endtask

    initial begin
        test_reset();
        test_arm();
        test_group_conflict();
        test_short_yellow();
        test_priority_clear();
        test_startup_ignore();
        test_reset_in_fault();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/traffic_conflict_monitor.md
# traffic_conflict_monitor

Independent safety monitor on the receiving end of the traffic controller's lamp interface. It samples the four approach lamp triplets and four walk signals on the system clock, checks them against the intersection's safety rules, and latches a fault with a cause code. The fault output drives the all-red override. It sits beside the controller at the top level and consumes exactly the signals the controller drives to the lamps.

## Interface
- PERSIST, 2: consecutive violating clk cycles required before a static violation latches a fault (1..15).
- MIN_YEL, 134217728: minimum clk cycles a yellow must be lit before that approach turns red.
- YCNT_W, 28: width of each yellow-duration counter; must hold MIN_YEL.
- clk  in  1  system clock; lamps are sampled on every rising edge.
- reset  in  1  synchronous, active-high reset.
- s1_r, s1_g, s1_y … s4_r, s4_g, s4_y  in  1 each  lamp drives for approaches 1–4.
- P1, P2, P3, P4  in  1 each  walk signals.
- clear_fault  in  1  single-cycle request to leave FAULT.
- fault  out  1  latched fault.
- force_red  out  1  all-red override request; equal to fault.
- fault_code  out  3  cause: 0 none, 1 illegal lamp, 2 group conflict, 3 walk conflict, 4 short yellow.
- armed  out  1  high in MONITOR or PENDING.
- fault_cnt  out  8  number of FAULT entries since reset; saturates at 255.

## Operation
- Groups: A = approaches 1,2; B = approaches 3,4. An approach is "go" when its g or y is lit.
- Violations are evaluated combinationally each cycle:
  - Illegal lamp (1): any approach with other than exactly one of r/g/y lit.
  - Group conflict (2): any A approach is go while any B approach is go.
  - Walk conflict (3): P3 or P4 is high while s3 or s4 is go.
  - Short yellow (4): an approach had y lit last cycle and shows r only this cycle, and its yellow counter is below MIN_YEL.
- Static priority when several violations coincide: 2 > 3 > 1 > 4.
- Yellow counters, one per approach:
  - Increment each cycle that approach's y is lit; saturate at MIN_YEL.
  - Clear to 0 on any cycle y is not lit.
  - Run in every state.
  - A yellow-to-green transition is not checked.
- FSM:
  - STARTUP: all violations ignored. Go to MONITOR on the first cycle all four approaches show r only.
  - MONITOR:
    - Short yellow goes directly to FAULT.
    - Any static violation (1–3) goes to PENDING with the persist counter at 1, or directly to FAULT if PERSIST = 1.
  - PENDING:
    - No violation returns to MONITOR and clears the persist counter.
    - Short yellow goes to FAULT.
    - Otherwise the persist counter increments; when it reaches PERSIST, go to FAULT.
    - A change in the kind of static violation does not restart the count.
  - FAULT:
    - fault = force_red = 1; fault_code holds the code that caused entry.
    - Leave only when clear_fault = 1 and no violation is present that cycle; then go to STARTUP, which re-arms on all-red.
    - clear_fault in any other state is ignored.
- fault_cnt increments on each transition into FAULT and is not affected by clear_fault.

## Timing
- Reset values: state STARTUP; fault 0, force_red 0, fault_code 0, armed 0, fault_cnt 0; yellow and persist counters 0.
- All outputs are registered. fault rises on the edge after the violating cycle that satisfies the entry condition.
  - Static violation beginning at cycle n, PERSIST = 2: fault high at n+2.
  - Short yellow detected at cycle n: fault high at n+1.
- fault_code updates on the same edge as fault rises. It returns to 0 on the edge that leaves FAULT.
- armed rises one edge after the all-red cycle seen in STARTUP.
- reset asserted mid-PENDING or mid-FAULT returns everything to reset values on the next edge. It overrides clear_fault and any violation that cycle.
- A violation lasting PERSIST−1 cycles, followed by one clean cycle, produces no fault.

## Test plan
Use PERSIST=2, MIN_YEL=4, YCNT_W=4.
- Reset, then all-red for 1 cycle, then legal sequence s1/s2 green, s1/s2 yellow for 4 cycles, all red -> armed=1, fault stays 0, fault_cnt 0.
- In MONITOR, drive s1_g and s3_g together for 1 cycle, then clean -> no fault. Drive them for 2 cycles -> fault=1 and fault_code=2 two edges after onset; force_red=1; fault_cnt=1.
- In MONITOR, s2 yellow for 3 cycles, then red -> fault=1, fault_code=4 one edge later. A 4-cycle yellow -> no fault.
- s3_g with P3=1 and s1_g, all in the same cycle, held 2 cycles -> fault_code=2 (priority over 3). Then pulse clear_fault while the violation persists -> still FAULT. Remove the violation and pulse clear_fault -> STARTUP, fault=0, armed=0 until all-red is seen.
- Before the first all-red, drive s4_r and s4_g together for 10 cycles -> no fault, armed=0.
- Enter FAULT, assert reset together with clear_fault -> next edge: all outputs 0, fault_cnt=0.
